// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI bus arbiter: FSM state encoding and one-hot helper.
package spi_arb_pkg;

  localparam int N_REQ_DEF   = 3;
  localparam int DW_DEF      = 16;
  localparam int TO_CYC_DEF  = 100000;
  localparam int GAP_CYC_DEF = 16;
  localparam int MAX_REQ     = 32;

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    LOAD = 5'b00010,
    RUN  = 5'b00100,
    DONE = 5'b01000,
    GAP  = 5'b10000
  } state_t;

  function automatic logic [MAX_REQ-1:0] onehot(input int idx);
    return {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Link between the arbiter and the single SPI master: word/count/start out, readback and done back.
interface spi_bus_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int DW    = 16
);
  logic [DW-1:0]    o_dat_in;
  logic             o_opt_start;
  logic [7:0]       o_opt_cnt;
  logic [N_REQ-1:0] o_cs_sel;
  logic [7:0]       i_dat_out;
  logic             i_dat_vaild;
  logic             i_spi_done;

  modport master (
    output o_dat_in, o_opt_start, o_opt_cnt, o_cs_sel,
    input  i_dat_out, i_dat_vaild, i_spi_done
  );

  modport slave (
    input  o_dat_in, o_opt_start, o_opt_cnt, o_cs_sel,
    output i_dat_out, i_dat_vaild, i_spi_done
  );
endinterface

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping at N_REQ.
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic               w_found;
  int                 w_off;
  int                 w_sum;
  logic [MAX_REQ-1:0] w_oh;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  always_comb begin
    w_found = 1'b0;
    w_off   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = k;
      end
    end
  end

  always_comb begin
    w_sum = int'(i_ptr) + w_off;
    if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
  end

  assign w_oh  = onehot(w_sum);
  assign o_gnt = w_found ? w_oh[N_REQ-1:0] : '0;
  assign o_idx = IW'(w_sum);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI master among N_REQ controllers: round-robin grant, timeout watchdog, idle gap.
// Grant 1 cycle after request, start 1 cycle later; back in IDLE GAP_CYC+2 cycles after done.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int TO_CYC  = TO_CYC_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ*DW-1:0] i_req_dat,
  input  logic [N_REQ*8-1:0]  i_req_cnt,
  output logic [N_REQ-1:0]    o_gnt,
  output logic [N_REQ-1:0]    o_done,
  output logic [N_REQ-1:0]    o_err,
  output logic [7:0]          o_rd_dat,
  output logic [N_REQ-1:0]    o_rd_vld,
  output logic                o_busy,
  spi_bus_arbiter_if.master   spi
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 2);

  state_t           r_state, w_state;
  logic [IW-1:0]    r_ptr, w_ptr, r_win, w_win;
  logic [N_REQ-1:0] r_gnt, w_gnt, r_done, w_done, r_err, w_err, r_rd_vld, w_rd_vld;
  logic [DW-1:0]    r_dat, w_dat;
  logic [7:0]       r_cnt, w_cnt, r_rd_dat, w_rd_dat;
  logic             r_start, w_start;
  logic [TW-1:0]    r_to, w_to;
  logic [GW-1:0]    r_gap, w_gap;
  logic [N_REQ-1:0] w_arb_gnt;
  logic [IW-1:0]    w_arb_idx;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_err    <= '0;
      r_rd_vld <= '0;
      r_dat    <= '0;
      r_cnt    <= '0;
      r_rd_dat <= '0;
      r_start  <= 1'b0;
      r_to     <= '0;
      r_gap    <= '0;
    end else begin
      r_state  <= w_state;
      r_ptr    <= w_ptr;
      r_win    <= w_win;
      r_gnt    <= w_gnt;
      r_done   <= w_done;
      r_err    <= w_err;
      r_rd_vld <= w_rd_vld;
      r_dat    <= w_dat;
      r_cnt    <= w_cnt;
      r_rd_dat <= w_rd_dat;
      r_start  <= w_start;
      r_to     <= w_to;
      r_gap    <= w_gap;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_ptr    = r_ptr;
    w_win    = r_win;
    w_gnt    = r_gnt;
    w_done   = '0;
    w_err    = '0;
    w_rd_vld = '0;
    w_dat    = r_dat;
    w_cnt    = r_cnt;
    w_rd_dat = r_rd_dat;
    w_start  = r_start;
    w_to     = r_to;
    w_gap    = r_gap;
    unique case (r_state)
      IDLE: begin
        if (|i_req) begin
          w_win   = w_arb_idx;
          w_gnt   = w_arb_gnt;
          w_dat   = i_req_dat[int'(w_arb_idx)*DW +: DW];
          w_cnt   = i_req_cnt[int'(w_arb_idx)*8 +: 8];
          w_state = LOAD;
        end
      end
      LOAD: begin
        w_start = 1'b1;
        w_to    = '0;
        w_state = RUN;
      end
      RUN: begin
        if (spi.i_dat_vaild) begin
          w_rd_vld = r_gnt;
          w_rd_dat = spi.i_dat_out;
        end
        w_to = r_to + TW'(1);
        // A done arriving on the expiry cycle still counts as a clean completion.
        if (spi.i_spi_done) begin
          w_start = 1'b0;
          w_done  = r_gnt;
          w_state = DONE;
        end else if (r_to == TW'(TO_CYC - 1)) begin
          w_start = 1'b0;
          w_done  = r_gnt;
          w_err   = r_gnt;
          w_state = DONE;
        end
      end
      DONE: begin
        w_gnt   = '0;
        w_ptr   = (r_win == IW'(N_REQ - 1)) ? '0 : r_win + IW'(1);
        w_gap   = '0;
        w_state = GAP;
      end
      GAP: begin
        w_gap = r_gap + GW'(1);
        if (r_gap == GW'(GAP_CYC)) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  assign o_gnt           = r_gnt;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_rd_vld        = r_rd_vld;
  assign o_rd_dat        = r_rd_dat;
  assign o_busy          = (r_state != IDLE);
  assign spi.o_dat_in    = r_dat;
  assign spi.o_opt_start = r_start;
  assign spi.o_opt_cnt   = r_cnt;
  assign spi.o_cs_sel    = r_gnt;

endmodule
